board_controller: RTL and testbench
===================================

# board_controller

Game-state engine that sits directly upstream of the VGA board renderer. It holds the 64-square board, the cursor and the selection, and executes piece moves in response to single-cycle button pulses. It drives the renderer's `BOARD`, `CURSOR_ADDR`, `SELECT_ADDR` and `SELECT_EN` inputs. Only basic move rules are checked: turn ownership and no capture of own pieces. Piece movement rules are not validated.

## Interface
- `CURSOR_RESET`, default 6'd52: cursor square after reset (row 6, col 4).
- `CLK`  in  1  system clock; all logic on the rising edge.
- `RESET_N`  in  1  one clock; reset is asynchronous, active-low.
- `BTN_UP`, `BTN_DOWN`, `BTN_LEFT`, `BTN_RIGHT`, `BTN_SEL`  in  1 each  already-debounced single-cycle pulses.
- `BOARD`  out  256  square i in bits [4i+3:4i]; i = {row[2:0], col[2:0]}; bit3 = colour (0 white, 1 black); bits[2:0] = piece (0 none, 1 pawn, 2 knight, 3 bishop, 4 rook, 5 queen, 6 king).
- `CURSOR_ADDR`  out  6  {row, col} of the cursor.
- `SELECT_ADDR`  out  6  {row, col} of the selected square.
- `SELECT_EN`  out  1  selection valid.
- `TURN`  out  1  side to move (0 white, 1 black).
- `MOVE_DONE`  out  1  one-cycle pulse when a move completes.

## Operation
- Reset values:
  - `BOARD` is the standard start position. Rows 0–1 are black, rows 6–7 are white, pawns are on rows 1 and 6.
  - Back rank, cols 0..7: rook, knight, bishop, queen, king, bishop, knight, rook.
  - `CURSOR_ADDR` = `CURSOR_RESET`; `SELECT_ADDR` = 0; `SELECT_EN` = 0; `TURN` = 0; `MOVE_DONE` = 0; state = IDLE.
- Button priority within one cycle: SEL > UP > DOWN > LEFT > RIGHT. At most one action is taken per cycle; lower-priority pulses are dropped.
- Cursor movement:
  - UP: row−1. DOWN: row+1. LEFT: col−1. RIGHT: col+1.
  - The cursor clamps at the board edges (no wrap).
  - Moves are accepted in IDLE and SELECTED only.
- States:
  - IDLE:
    - SEL on a square holding a piece of colour `TURN` → `SELECT_ADDR` ← cursor, `SELECT_EN` ← 1, go to SELECTED.
    - SEL on any other square is ignored.
  - SELECTED:
    - SEL on `SELECT_ADDR` → `SELECT_EN` ← 0, go to IDLE.
    - SEL on another own-colour piece → `SELECT_ADDR` ← cursor, stay in SELECTED.
    - SEL on an empty or opposing square → latch destination (DEST) ← cursor, go to MOVE.
  - MOVE: `board[DEST]` ← `board[SELECT_ADDR]`, then go to CLEAR.
    - Promotion: a white pawn landing on row 0 or a black pawn landing on row 7 is written as a queen of the same colour.
  - CLEAR: `board[SELECT_ADDR]` ← 4'h0, `SELECT_EN` ← 0, `TURN` toggles, `MOVE_DONE` ← 1, go to IDLE.
- All buttons are ignored in MOVE and CLEAR.
- No king-capture or game-over detection; a captured king simply disappears.

## Timing
- All outputs are registered.
- Cursor and selection update on the edge that samples the pulse, so they are visible the next cycle (latency 1).
- Move sequence, where edge 0 samples the SEL pulse into MOVE:
  - after edge 1 the destination shows the piece and the source still holds it (a one-cycle duplicate, accepted);
  - after edge 2 the source is empty, `SELECT_EN` = 0, `TURN` is toggled and `MOVE_DONE` = 1;
  - after edge 3 `MOVE_DONE` = 0.
- Total move latency is 2 cycles. The next button is honoured from the cycle after edge 2.
- `RESET_N` asserted at any point, including mid-move, immediately restores every reset value. No partial move survives.
- The board may change at any cycle, so the renderer can show up to one frame of the intermediate board. This is acceptable.

## Structure
- Shared package `chess_pkg` holds:
  - the piece codes and colour constants, shared with the renderer;
  - a square-address helper;
  - a function returning the 256-bit start position.
- One sub-module `cursor_ctrl` owns the `CURSOR_ADDR` register. It receives one-hot direction pulses and an enable, and does the edge clamping.
- The FSM and the board register array live in `board_controller`.

## Test plan
- Reset → `BOARD[3:0]` = 4'b1100 (black rook at 0), `BOARD[211:208]` = 4'b0001 (white pawn at 52), `CURSOR_ADDR` = 52, `TURN` = 0.
- 10× `BTN_UP` from 52 → `CURSOR_ADDR` = 4 (row 0, col 4) and stays there; `BTN_LEFT` + `BTN_UP` in the same cycle from 52 → 44 (UP wins).
- White turn, SEL at 52, UP×2, SEL → square 36 = 4'b0001 and square 52 = 0 two cycles after the second SEL; `MOVE_DONE` pulses once; `TURN` = 1.
- Black turn, SEL on white piece at 48 → ignored (`SELECT_EN` = 0). SEL on 12 then SEL on 12 → `SELECT_EN` 1 then 0. SEL on 12 then SEL on 8 (own rook... pawn) → `SELECT_ADDR` = 8.
- Preload via moves a white pawn on 8 and square 0 vacated; move 8→0 → square 0 = 4'b0101 (white queen).
- Assert `RESET_N` the cycle after entering MOVE → start position restored, `MOVE_DONE` never pulses.

Source files
------------

// File: rtl/board_controller_pkg.sv
// chess_pkg: shared chess encodings for the board controller and the VGA
// renderer.
// Contents:
//   - piece codes and colour constants
//   - the packed 256-bit board type
//   - the FSM state type
//   - a square-address helper
//   - a function that builds the standard start position
package chess_pkg;

  localparam logic [2:0] PIECE_NONE   = 3'd0;
  localparam logic [2:0] PIECE_PAWN   = 3'd1;
  localparam logic [2:0] PIECE_KNIGHT = 3'd2;
  localparam logic [2:0] PIECE_BISHOP = 3'd3;
  localparam logic [2:0] PIECE_ROOK   = 3'd4;
  localparam logic [2:0] PIECE_QUEEN  = 3'd5;
  localparam logic [2:0] PIECE_KING   = 3'd6;

  localparam logic COLOR_WHITE = 1'b0;
  localparam logic COLOR_BLACK = 1'b1;

  typedef logic [255:0] board_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SELECTED,
    ST_MOVE,
    ST_CLEAR
  } state_e;

  function automatic logic [5:0] sq_addr(input logic [2:0] row, input logic [2:0] col);
    return {row, col};
  endfunction

  function automatic logic [2:0] back_rank_piece(input logic [2:0] col);
    case (col)
      3'd0, 3'd7: return PIECE_ROOK;
      3'd1, 3'd6: return PIECE_KNIGHT;
      3'd2, 3'd5: return PIECE_BISHOP;
      3'd3:       return PIECE_QUEEN;
      default:    return PIECE_KING;
    endcase
  endfunction

  // Black occupies rows 0-1, white occupies rows 6-7.
  function automatic board_t start_board();
    board_t b;
    b = '0;
    for (int c = 0; c < 8; c++) begin
      b[{sq_addr(3'd0, 3'(c)), 2'b00} +: 4] = {COLOR_BLACK, back_rank_piece(3'(c))};
      b[{sq_addr(3'd1, 3'(c)), 2'b00} +: 4] = {COLOR_BLACK, PIECE_PAWN};
      b[{sq_addr(3'd6, 3'(c)), 2'b00} +: 4] = {COLOR_WHITE, PIECE_PAWN};
      b[{sq_addr(3'd7, 3'(c)), 2'b00} +: 4] = {COLOR_WHITE, back_rank_piece(3'(c))};
    end
    return b;
  endfunction

endpackage

// File: rtl/board_controller_if.sv
// board_controller_if: bundles the button pulses and the renderer-facing
// outputs of the board controller.
// Modports:
//   - master: drives the buttons and observes the board state (test or
//     input side).
//   - slave: the board controller itself.
interface board_controller_if;
  import chess_pkg::*;

  logic       BTN_UP;
  logic       BTN_DOWN;
  logic       BTN_LEFT;
  logic       BTN_RIGHT;
  logic       BTN_SEL;
  board_t     BOARD;
  logic [5:0] CURSOR_ADDR;
  logic [5:0] SELECT_ADDR;
  logic       SELECT_EN;
  logic       TURN;
  logic       MOVE_DONE;

  modport master (
    output BTN_UP, BTN_DOWN, BTN_LEFT, BTN_RIGHT, BTN_SEL,
    input  BOARD, CURSOR_ADDR, SELECT_ADDR, SELECT_EN, TURN, MOVE_DONE
  );

  modport slave (
    input  BTN_UP, BTN_DOWN, BTN_LEFT, BTN_RIGHT, BTN_SEL,
    output BOARD, CURSOR_ADDR, SELECT_ADDR, SELECT_EN, TURN, MOVE_DONE
  );
endinterface

// File: rtl/board_controller_cursor_ctrl.sv
// cursor_ctrl: owns the cursor register.
// Ports:
//   - clk, rst_n: clock and asynchronous active-low reset.
//   - en: allows the cursor to move.
//   - dir_up, dir_down, dir_left, dir_right: one-hot step requests.
//   - cursor_addr: registered {row, col}.
// The cursor clamps at the board edges and never wraps.
module cursor_ctrl
  import chess_pkg::*;
#(
  parameter logic [5:0] CURSOR_RESET = 6'd52
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       dir_up,
  input  logic       dir_down,
  input  logic       dir_left,
  input  logic       dir_right,
  output logic [5:0] cursor_addr
);

  logic [5:0] cursor_q;
  logic [5:0] cursor_d;
  logic [2:0] row;
  logic [2:0] col;

  assign row = cursor_q[5:3];
  assign col = cursor_q[2:0];

  always_comb begin
    cursor_d = cursor_q;
    if (en) begin
      if (dir_up && row != 3'd0) begin
        cursor_d = sq_addr(row - 3'd1, col);
      end else if (dir_down && row != 3'd7) begin
        cursor_d = sq_addr(row + 3'd1, col);
      end else if (dir_left && col != 3'd0) begin
        cursor_d = sq_addr(row, col - 3'd1);
      end else if (dir_right && col != 3'd7) begin
        cursor_d = sq_addr(row, col + 3'd1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cursor_q <= CURSOR_RESET;
    else        cursor_q <= cursor_d;
  end

  assign cursor_addr = cursor_q;

endmodule

// File: rtl/board_controller.sv
// board_controller: chess game-state engine in front of the VGA renderer.
// It holds the 64-square board, the selection and the side to move. It
// turns button pulses into selections and two-cycle moves: the first cycle
// writes the destination, the second clears the source and hands the turn
// over. Only turn ownership and no-self-capture are enforced.
// Ports:
//   - CLK, RESET_N: clock and asynchronous active-low reset.
//   - bus (slave): the buttons in; BOARD, CURSOR_ADDR, SELECT_ADDR,
//     SELECT_EN, TURN and MOVE_DONE out. All outputs are registered.
module board_controller
  import chess_pkg::*;
#(
  parameter logic [5:0] CURSOR_RESET = 6'd52
) (
  input logic           CLK,
  input logic           RESET_N,
  board_controller_if.slave bus
);

  state_e     state_q, state_d;
  board_t     board_q, board_d;
  logic [5:0] sel_addr_q, sel_addr_d;
  logic       sel_en_q, sel_en_d;
  logic [5:0] dest_q, dest_d;
  logic       turn_q, turn_d;
  logic       move_done_q, move_done_d;

  logic [5:0] cursor;
  logic       cur_en;
  logic       go_up, go_down, go_left, go_right;
  logic [3:0] cur_sq;
  logic       cur_own;
  logic [3:0] moving;

  // SEL outranks every direction, so a SEL cycle never moves the cursor.
  assign go_up    = !bus.BTN_SEL && bus.BTN_UP;
  assign go_down  = !bus.BTN_SEL && !bus.BTN_UP && bus.BTN_DOWN;
  assign go_left  = !bus.BTN_SEL && !bus.BTN_UP && !bus.BTN_DOWN && bus.BTN_LEFT;
  assign go_right = !bus.BTN_SEL && !bus.BTN_UP && !bus.BTN_DOWN && !bus.BTN_LEFT
                    && bus.BTN_RIGHT;
  assign cur_en   = (state_q == ST_IDLE) || (state_q == ST_SELECTED);

  cursor_ctrl #(.CURSOR_RESET(CURSOR_RESET)) u_cursor (
    .clk        (CLK),
    .rst_n      (RESET_N),
    .en         (cur_en),
    .dir_up     (go_up),
    .dir_down   (go_down),
    .dir_left   (go_left),
    .dir_right  (go_right),
    .cursor_addr(cursor)
  );

  assign cur_sq  = board_q[{cursor, 2'b00} +: 4];
  assign cur_own = (cur_sq[2:0] != PIECE_NONE) && (cur_sq[3] == turn_q);

  // A pawn that reaches the far rank is written as a queen of the same colour.
  always_comb begin
    moving = board_q[{sel_addr_q, 2'b00} +: 4];
    if (moving[2:0] == PIECE_PAWN &&
        ((moving[3] == COLOR_WHITE && dest_q[5:3] == 3'd0) ||
         (moving[3] == COLOR_BLACK && dest_q[5:3] == 3'd7))) begin
      moving = {moving[3], PIECE_QUEEN};
    end
  end

  always_comb begin
    state_d     = state_q;
    board_d     = board_q;
    sel_addr_d  = sel_addr_q;
    sel_en_d    = sel_en_q;
    dest_d      = dest_q;
    turn_d      = turn_q;
    move_done_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.BTN_SEL && cur_own) begin
          sel_addr_d = cursor;
          sel_en_d   = 1'b1;
          state_d    = ST_SELECTED;
        end
      end
      ST_SELECTED: begin
        if (bus.BTN_SEL) begin
          if (cursor == sel_addr_q) begin
            sel_en_d = 1'b0;
            state_d  = ST_IDLE;
          end else if (cur_own) begin
            sel_addr_d = cursor;
          end else begin
            dest_d  = cursor;
            state_d = ST_MOVE;
          end
        end
      end
      // The source is still intact here; it is cleared one cycle later.
      ST_MOVE: begin
        board_d[{dest_q, 2'b00} +: 4] = moving;
        state_d = ST_CLEAR;
      end
      ST_CLEAR: begin
        board_d[{sel_addr_q, 2'b00} +: 4] = 4'h0;
        sel_en_d    = 1'b0;
        turn_d      = ~turn_q;
        move_done_d = 1'b1;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= ST_IDLE;
      board_q     <= start_board();
      sel_addr_q  <= 6'd0;
      sel_en_q    <= 1'b0;
      dest_q      <= 6'd0;
      turn_q      <= COLOR_WHITE;
      move_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      board_q     <= board_d;
      sel_addr_q  <= sel_addr_d;
      sel_en_q    <= sel_en_d;
      dest_q      <= dest_d;
      turn_q      <= turn_d;
      move_done_q <= move_done_d;
    end
  end

  assign bus.BOARD       = board_q;
  assign bus.CURSOR_ADDR = cursor;
  assign bus.SELECT_ADDR = sel_addr_q;
  assign bus.SELECT_EN   = sel_en_q;
  assign bus.TURN        = turn_q;
  assign bus.MOVE_DONE   = move_done_q;

endmodule

// File: tb/tb_board_controller.sv
// tb_board_controller: drives board_controller with directed game sequences
// and random button traffic. Every cycle the outputs are compared against a
// square-array model of the chess rules.
module tb_board_controller;
  import chess_pkg::*;

  localparam logic [4:0] B_NONE  = 5'b00000;
  localparam logic [4:0] B_SEL   = 5'b10000;
  localparam logic [4:0] B_UP    = 5'b01000;
  localparam logic [4:0] B_DOWN  = 5'b00100;
  localparam logic [4:0] B_LEFT  = 5'b00010;
  localparam logic [4:0] B_RIGHT = 5'b00001;

  logic clk;
  logic rst_n;
  board_controller_if bus ();

  board_controller #(.CURSOR_RESET(6'd52)) dut (
    .CLK    (clk),
    .RESET_N(rst_n),
    .bus    (bus.slave)
  );

  int checks;
  int failures;
  bit compare_en;

  // Reference model: plain per-square array plus game bookkeeping.
  int m_board[64];
  int m_row, m_col;
  bit m_sel;
  int m_saddr;
  int m_dest;
  int m_turn;
  int m_pending;
  bit m_done;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int back_piece(int c);
    int rank[8] = '{4, 2, 3, 5, 6, 3, 2, 4};
    return rank[c];
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 64; i++) m_board[i] = 0;
    for (int c = 0; c < 8; c++) begin
      m_board[c]      = 8 + back_piece(c);
      m_board[8 + c]  = 8 + 1;
      m_board[48 + c] = 1;
      m_board[56 + c] = back_piece(c);
    end
    m_row = 6; m_col = 4;
    m_sel = 0; m_saddr = 0; m_dest = 0;
    m_turn = 0; m_pending = 0; m_done = 0;
  endfunction

  function automatic void model_step(logic [4:0] b);
    int cur;
    int pc;
    int mv;
    bit own;
    cur = m_row * 8 + m_col;
    m_done = 0;
    if (m_pending == 2) begin
      mv = m_board[m_saddr];
      if ((mv % 8) == 1 && ((mv / 8 == 0 && m_dest / 8 == 0) || (mv / 8 == 1 && m_dest / 8 == 7)))
        mv = (mv / 8) * 8 + 5;
      m_board[m_dest] = mv;
      m_pending = 1;
    end else if (m_pending == 1) begin
      m_board[m_saddr] = 0;
      m_sel = 0;
      m_turn = 1 - m_turn;
      m_done = 1;
      m_pending = 0;
    end else if (b[4]) begin
      pc = m_board[cur];
      own = (pc % 8) != 0 && (pc / 8) == m_turn;
      if (!m_sel) begin
        if (own) begin m_sel = 1; m_saddr = cur; end
      end else if (cur == m_saddr) begin
        m_sel = 0;
      end else if (own) begin
        m_saddr = cur;
      end else begin
        m_dest = cur;
        m_pending = 2;
      end
    end else if (b[3]) begin
      if (m_row > 0) m_row--;
    end else if (b[2]) begin
      if (m_row < 7) m_row++;
    end else if (b[1]) begin
      if (m_col > 0) m_col--;
    end else if (b[0]) begin
      if (m_col < 7) m_col++;
    end
  endfunction

  function automatic logic [255:0] model_pack();
    logic [255:0] p;
    p = '0;
    for (int i = 0; i < 64; i++) p[i*4 +: 4] = 4'(m_board[i]);
    return p;
  endfunction

  task automatic checkOutput(input string name, input logic [255:0] actual,
                             input logic [255:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  // Called right after a rising edge; sets up the next cycle and models it.
  task automatic applyStimulus(input logic [4:0] b, input bit do_reset);
    {bus.BTN_SEL, bus.BTN_UP, bus.BTN_DOWN, bus.BTN_LEFT, bus.BTN_RIGHT} = b;
    if (do_reset) begin
      rst_n = 1'b0;
      model_reset();
    end else begin
      rst_n = 1'b1;
    end
    @(posedge clk);
    if (!do_reset) model_step(b);
    #1;
  endtask

  task automatic gotoSquare(input int target);
    int guard;
    guard = 0;
    while ((m_row * 8 + m_col) != target && guard < 20) begin
      if (m_row > target / 8)      applyStimulus(B_UP, 0);
      else if (m_row < target / 8) applyStimulus(B_DOWN, 0);
      else if (m_col > target % 8) applyStimulus(B_LEFT, 0);
      else                         applyStimulus(B_RIGHT, 0);
      guard++;
    end
    checkOutput("goto_reached", 256'(dut.bus.CURSOR_ADDR), 256'(target));
  endtask

  task automatic doMove(input int from, input int to);
    gotoSquare(from);
    applyStimulus(B_SEL, 0);
    gotoSquare(to);
    applyStimulus(B_SEL, 0);
    applyStimulus(B_NONE, 0);
    applyStimulus(B_NONE, 0);
  endtask

  task automatic resetBoard();
    applyStimulus(B_NONE, 1);
    applyStimulus(B_NONE, 1);
    applyStimulus(B_NONE, 0);
  endtask

  always @(negedge clk) begin
    if (compare_en) begin
      checkOutput("board", bus.BOARD, model_pack());
      checkOutput("cursor", 256'(bus.CURSOR_ADDR), 256'(m_row * 8 + m_col));
      checkOutput("select_en", 256'(bus.SELECT_EN), 256'(m_sel));
      if (m_sel) checkOutput("select_addr", 256'(bus.SELECT_ADDR), 256'(m_saddr));
      checkOutput("turn", 256'(bus.TURN), 256'(m_turn));
      checkOutput("move_done", 256'(bus.MOVE_DONE), 256'(m_done));
    end
  end

  initial begin
    checks = 0;
    failures = 0;
    compare_en = 0;
    rst_n = 1'b0;
    {bus.BTN_SEL, bus.BTN_UP, bus.BTN_DOWN, bus.BTN_LEFT, bus.BTN_RIGHT} = B_NONE;
    model_reset();
    @(posedge clk);
    #1;
    compare_en = 1;
    applyStimulus(B_NONE, 1);

    // Reset values.
    checkOutput("rst_sq0", 256'(bus.BOARD[3:0]), 256'(4'b1100));
    checkOutput("rst_sq52", 256'(bus.BOARD[211:208]), 256'(4'b0001));
    checkOutput("rst_cursor", 256'(bus.CURSOR_ADDR), 256'(52));
    checkOutput("rst_turn", 256'(bus.TURN), 256'(0));
    checkOutput("rst_sel_addr", 256'(bus.SELECT_ADDR), 256'(0));
    applyStimulus(B_NONE, 0);

    // Clamp at the top edge.
    for (int i = 0; i < 10; i++) applyStimulus(B_UP, 0);
    checkOutput("clamp_top", 256'(bus.CURSOR_ADDR), 256'(4));
    resetBoard();
    applyStimulus(B_LEFT | B_UP, 0);
    checkOutput("up_beats_left", 256'(bus.CURSOR_ADDR), 256'(44));
    resetBoard();

    // White pawn 52 -> 36.
    applyStimulus(B_SEL, 0);
    checkOutput("sel52_en", 256'(bus.SELECT_EN), 256'(1));
    applyStimulus(B_UP, 0);
    applyStimulus(B_UP, 0);
    applyStimulus(B_SEL, 0);
    applyStimulus(B_NONE, 0);
    checkOutput("dup_dest", 256'(bus.BOARD[147:144]), 256'(4'b0001));
    checkOutput("dup_src", 256'(bus.BOARD[211:208]), 256'(4'b0001));
    checkOutput("dup_done", 256'(bus.MOVE_DONE), 256'(0));
    applyStimulus(B_NONE, 0);
    checkOutput("mv_dest", 256'(bus.BOARD[147:144]), 256'(4'b0001));
    checkOutput("mv_src", 256'(bus.BOARD[211:208]), 256'(4'b0000));
    checkOutput("mv_done", 256'(bus.MOVE_DONE), 256'(1));
    checkOutput("mv_turn", 256'(bus.TURN), 256'(1));
    applyStimulus(B_NONE, 0);
    checkOutput("mv_done_end", 256'(bus.MOVE_DONE), 256'(0));

    // Black to move.
    gotoSquare(48);
    applyStimulus(B_SEL, 0);
    checkOutput("black_sel_white", 256'(bus.SELECT_EN), 256'(0));
    gotoSquare(12);
    applyStimulus(B_SEL, 0);
    checkOutput("sel12_on", 256'(bus.SELECT_EN), 256'(1));
    applyStimulus(B_SEL, 0);
    checkOutput("sel12_off", 256'(bus.SELECT_EN), 256'(0));
    applyStimulus(B_SEL, 0);
    gotoSquare(8);
    applyStimulus(B_SEL, 0);
    checkOutput("reselect_8", 256'(bus.SELECT_ADDR), 256'(8));
    checkOutput("reselect_en", 256'(bus.SELECT_EN), 256'(1));

    // Promotion of a white pawn on square 0.
    resetBoard();
    doMove(48, 8);
    doMove(0, 16);
    doMove(8, 0);
    checkOutput("promote_q", 256'(bus.BOARD[3:0]), 256'(4'b0101));
    checkOutput("promote_src", 256'(bus.BOARD[35:32]), 256'(4'b0000));

    // Reset in the middle of a move.
    resetBoard();
    applyStimulus(B_SEL, 0);
    applyStimulus(B_UP, 0);
    applyStimulus(B_SEL, 0);
    applyStimulus(B_NONE, 1);
    checkOutput("midmove_board", bus.BOARD, start_board());
    checkOutput("midmove_turn", 256'(bus.TURN), 256'(0));
    for (int i = 0; i < 4; i++) begin
      applyStimulus(B_NONE, 0);
      checkOutput("midmove_no_done", 256'(bus.MOVE_DONE), 256'(0));
    end
    checkOutput("midmove_board_hold", bus.BOARD, start_board());

    // Random traffic.
    for (int i = 0; i < 4000; i++) begin
      logic [4:0] b;
      b[4] = ($urandom_range(0, 3) == 0);
      b[3] = ($urandom_range(0, 3) == 0);
      b[2] = ($urandom_range(0, 3) == 0);
      b[1] = ($urandom_range(0, 3) == 0);
      b[0] = ($urandom_range(0, 3) == 0);
      applyStimulus(b, $urandom_range(0, 599) == 0);
    end

    applyStimulus(B_NONE, 0);
    compare_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
